simple_cpu_param: RTL and testbench
===================================

SIMPLE_CPU_PARAM -- requirements
Module: simple_cpu_param

Interface
REQ-001 Parameter DATA_W, default 8: register, immediate and write_data width.
REQ-002 Parameter ADDR_W, default 4: register index width; register file holds 2**ADDR_W registers.
REQ-003 Parameter PC_W, default 6: program counter and instr_addr width.
REQ-004 Derived INSTR_W = 4+2*ADDR_W+DATA_W; fields MSB->LSB: opcode[3:0], rd[ADDR_W], rs[ADDR_W], imm[DATA_W].
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 halt  input  1  level pause request, sampled only in FETCH/PAUSED.
REQ-008 step  input  1  single-instruction advance pulse, honoured only in PAUSED.
REQ-009 instr_data  input  INSTR_W  instruction word for instr_addr, combinationally valid in the same cycle.
REQ-010 instr_addr  output  PC_W  current program counter.
REQ-011 write_valid  output  1  one-cycle pulse marking a register writeback.
REQ-012 write_addr  output  ADDR_W  destination register of the last writeback.
REQ-013 write_data  output  DATA_W  value written by the last writeback.
REQ-014 zero  output  1  zero flag of the last ALU writeback.
REQ-015 halted  output  1  high in PAUSED or HALTED.

Function
REQ-016 FSM states FETCH, DECODE, EXECUTE, WRITEBACK, PAUSED, HALTED; every instruction takes exactly 4 cycles FETCH->DECODE->EXECUTE->WRITEBACK.
REQ-017 FETCH: if halt=1 go to PAUSED without latching; else latch instr_data into IR, go to DECODE.
REQ-018 DECODE: read rd and rs register values into operand registers.
REQ-019 EXECUTE: compute result into a result register; evaluate jump condition.
REQ-020 WRITEBACK: perform register write/PC update; go to FETCH, except HLT goes to HALTED.
REQ-021 Opcodes: 0 NOP; 1 LDI rd=imm; 2 ADD rd=rd+rs; 3 SUB rd=rd-rs; 4 AND; 5 OR; 6 XOR; 7 MOV rd=rs.
REQ-022 Opcodes: 8 JMP pc=imm[PC_W-1:0]; 9 JZ pc=imm[PC_W-1:0] if reg[rd]==0; 15 HLT; 10-14 execute as NOP.
REQ-023 Arithmetic modulo 2**DATA_W; no carry, overflow ignored.
REQ-024 Opcodes 1-7: in WRITEBACK write reg[rd], write_valid=1 for that cycle, write_addr=rd, write_data=result, zero=(result==0).
REQ-025 write_addr, write_data, zero hold their values until the next writeback; write_valid=0 in all other cycles.
REQ-026 Non-jump, non-taken-jump instructions: pc=pc+1 modulo 2**PC_W in WRITEBACK (wraps 2**PC_W-1 -> 0).
REQ-027 halt asserted mid-instruction: current instruction completes; PAUSED entered at next FETCH; instr_addr frozen.
REQ-028 PAUSED: step=1 executes exactly one instruction from FETCH (latched regardless of halt), then re-evaluates halt at FETCH; halt=0 and step=0 resumes normal fetch.
REQ-029 HALTED: no fetch, no writes; halt and step ignored; exit only via reset.
REQ-030 No hazards: every instruction observes all results of the previous instruction.

Reset
REQ-031 reset=0 asynchronously forces state FETCH, pc=0, all registers 0, IR 0, write_valid=0, write_addr=0, write_data=0, zero=0, halted=0.
REQ-032 Reset asserted mid-instruction aborts it with no partial writeback; execution restarts at pc=0 on the first edge after release.

Verification
REQ-033 Reset hold then release: all outputs 0, instr_addr=0; first write_valid no earlier than the 4th edge after release.
REQ-034 LDI r1,5; LDI r2,3; ADD r1,r2 -> pulses (1,5),(2,3),(1,8) exactly 4 cycles apart; instr_addr 0,1,2,3.
REQ-035 SUB r1,r1 then JZ r1,0x20 -> write (1,0) with zero=1, next instr_addr=0x20, no write pulse for JZ; JZ on nonzero register falls through to pc+1.
REQ-036 LDI r3,0xFF; LDI r4,1; ADD r3,r4 -> write (3,0x00), zero=1; NOP at pc=63 -> next instr_addr=0.
REQ-037 halt=1 during EXECUTE -> current write completes, halted=1, instr_addr frozen 20+ cycles; one step pulse -> exactly one write pulse, then halted again; halt=0 -> resume.
REQ-038 HLT -> halted=1 permanently despite halt/step toggling; reset pulse clears halted and restarts at pc=0.

Source files
------------

// File: rtl/simple_cpu_param.sv
// Parameterised four-cycle multicycle CPU: FETCH/DECODE/EXECUTE/WRITEBACK with
// halt/step debug control and a registered writeback report port.
module simple_cpu_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int PC_W   = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           halt,
  input  logic                           step,
  input  logic [4+2*ADDR_W+DATA_W-1:0]   instr_data,
  output logic [PC_W-1:0]                instr_addr,
  output logic                           write_valid,
  output logic [ADDR_W-1:0]              write_addr,
  output logic [DATA_W-1:0]              write_data,
  output logic                           zero,
  output logic                           halted,
  output logic [2:0]                     dbg_state
);

  localparam int INSTR_W = 4 + 2*ADDR_W + DATA_W;
  localparam int NREGS   = 2**ADDR_W;

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_WRITEBACK = 3'd3;
  localparam logic [2:0] S_PAUSED    = 3'd4;
  localparam logic [2:0] S_HALTED    = 3'd5;

  localparam logic [3:0] OP_LDI = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_JMP = 4'd8;
  localparam logic [3:0] OP_JZ  = 4'd9;
  localparam logic [3:0] OP_HLT = 4'd15;

  logic [2:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic [DATA_W-1:0]  op_a_q, op_b_q, res_q;
  logic               jump_q;
  logic               step_q;
  logic [DATA_W-1:0]  regs_q [NREGS];
  logic               write_valid_q;
  logic [ADDR_W-1:0]  write_addr_q;
  logic [DATA_W-1:0]  write_data_q;
  logic               zero_q;

  logic [3:0]         opcode;
  logic [ADDR_W-1:0]  rd, rs;
  logic [DATA_W-1:0]  imm;
  logic [DATA_W-1:0]  alu;
  logic               is_write;

  assign opcode   = ir_q[INSTR_W-1 -: 4];
  assign rd       = ir_q[2*ADDR_W+DATA_W-1 -: ADDR_W];
  assign rs       = ir_q[ADDR_W+DATA_W-1 -: ADDR_W];
  assign imm      = ir_q[DATA_W-1:0];
  assign is_write = (opcode != 4'd0) && (opcode <= OP_MOV);

  always_comb begin
    alu = '0;
    case (opcode)
      OP_LDI:  alu = imm;
      OP_ADD:  alu = op_a_q + op_b_q;
      OP_SUB:  alu = op_a_q - op_b_q;
      OP_AND:  alu = op_a_q & op_b_q;
      OP_OR:   alu = op_a_q | op_b_q;
      OP_XOR:  alu = op_a_q ^ op_b_q;
      OP_MOV:  alu = op_b_q;
      default: alu = '0;
    endcase
  end

  // A pending step forces the next FETCH to latch even while halt is held.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     state_d = (halt && !step_q) ? S_PAUSED : S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = (opcode == OP_HLT) ? S_HALTED : S_FETCH;
      S_PAUSED:    if (step || !halt) state_d = S_FETCH;
      S_HALTED:    state_d = S_HALTED;
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_FETCH;
      pc_q          <= '0;
      ir_q          <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      res_q         <= '0;
      jump_q        <= 1'b0;
      step_q        <= 1'b0;
      write_valid_q <= 1'b0;
      write_addr_q  <= '0;
      write_data_q  <= '0;
      zero_q        <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      write_valid_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (state_d == S_DECODE) begin
            ir_q   <= instr_data;
            step_q <= 1'b0;
          end
        end
        S_DECODE: begin
          op_a_q <= regs_q[rd];
          op_b_q <= regs_q[rs];
        end
        S_EXECUTE: begin
          res_q  <= alu;
          jump_q <= (opcode == OP_JMP) || ((opcode == OP_JZ) && (op_a_q == '0));
        end
        S_WRITEBACK: begin
          if (is_write) begin
            regs_q[rd]    <= res_q;
            write_valid_q <= 1'b1;
            write_addr_q  <= rd;
            write_data_q  <= res_q;
            zero_q        <= (res_q == '0);
          end
          pc_q <= jump_q ? PC_W'(imm) : pc_q + PC_W'(1);
        end
        S_PAUSED: begin
          if (step) step_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign instr_addr  = pc_q;
  assign write_valid = write_valid_q;
  assign write_addr  = write_addr_q;
  assign write_data  = write_data_q;
  assign zero        = zero_q;
  assign halted      = (state_q == S_PAUSED) || (state_q == S_HALTED);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_simple_cpu_param.sv
// Bench for simple_cpu_param: an ISA reference model fills an expected-write
// queue from the loaded program; a negedge monitor pops and compares each writeback.
module tb_simple_cpu_param;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int PC_W    = 6;
  localparam int INSTR_W = 4 + 2*ADDR_W + DATA_W;
  localparam int EW      = PC_W + ADDR_W + DATA_W + 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               halt;
  logic               step;
  logic [INSTR_W-1:0] instr_data;
  logic [PC_W-1:0]    instr_addr;
  logic               write_valid;
  logic [ADDR_W-1:0]  write_addr;
  logic [DATA_W-1:0]  write_data;
  logic               zero;
  logic               halted;
  logic [2:0]         dbg_state;

  logic [INSTR_W-1:0] mem [2**PC_W];
  logic [EW-1:0]      exp_q [$];
  int                 wcyc [$];
  int                 n_checks = 0;
  int                 n_pass   = 0;
  int                 cyc      = 0;
  int                 rel_cyc  = 0;
  int                 writes   = 0;

  simple_cpu_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .halt       (halt),
    .step       (step),
    .instr_data (instr_data),
    .instr_addr (instr_addr),
    .write_valid(write_valid),
    .write_addr (write_addr),
    .write_data (write_data),
    .zero       (zero),
    .halted     (halted),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign instr_data = mem[instr_addr];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset && write_valid) begin
      writes++;
      wcyc.push_back(cyc);
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check("write", 32'({instr_addr, write_addr, write_data, zero}), 32'(exp_q.pop_front()));
    end
  end

  function automatic logic [INSTR_W-1:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                             input logic [3:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 2**PC_W; i++) mem[i] = enc(4'd0, 4'd0, 4'd0, 8'd0);
  endtask

  // ISA reference model: runs from pc 0 with cleared registers
  task automatic model_run(input int max_instr);
    logic [7:0] r [16];
    logic [5:0] pc, nxt;
    logic [3:0] op, rd, rs;
    logic [7:0] imm, a, b, res;
    logic [INSTR_W-1:0] w;
    for (int i = 0; i < 16; i++) r[i] = 8'd0;
    pc = 6'd0;
    for (int n = 0; n < max_instr; n++) begin
      w = mem[pc];
      {op, rd, rs, imm} = w;
      a = r[rd]; b = r[rs];
      nxt = pc + 6'd1;
      res = 8'd0;
      if (op == 4'd15) break;
      if (op >= 4'd1 && op <= 4'd7) begin
        case (op)
          4'd1: res = imm;
          4'd2: res = a + b;
          4'd3: res = a - b;
          4'd4: res = a & b;
          4'd5: res = a | b;
          4'd6: res = a ^ b;
          default: res = b;
        endcase
        r[rd] = res;
        exp_q.push_back({nxt, rd, res, res == 8'd0});
      end else if (op == 4'd8 || (op == 4'd9 && a == 8'd0)) begin
        nxt = imm[5:0];
      end
      pc = nxt;
    end
  endtask

  // driver tasks
  task automatic do_reset(input string tag);
    reset = 1'b0;
    halt  = 1'b0;
    step  = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_rst_addr"},   32'(instr_addr),  32'd0);
    check({tag, "_rst_wvalid"}, 32'(write_valid), 32'd0);
    check({tag, "_rst_waddr"},  32'(write_addr),  32'd0);
    check({tag, "_rst_wdata"},  32'(write_data),  32'd0);
    check({tag, "_rst_zero"},   32'(zero),        32'd0);
    check({tag, "_rst_halted"}, 32'(halted),      32'd0);
    exp_q.delete();
    wcyc.delete();
  endtask

  task automatic release_reset();
    reset   = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic wait_halted(input string tag, input int bound);
    int k = 0;
    while (!halted && k < bound) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_halt_reached"}, 32'(halted), 32'd1);
  endtask

  initial begin
    int bad, w0;
    reset = 1'b0; halt = 1'b0; step = 1'b0;
    clear_mem();

    // reset state, then straight-line LDI/LDI/ADD with 4-cycle spacing
    do_reset("a");
    mem[0] = enc(4'd1, 4'd1, 4'd0, 8'd5);
    mem[1] = enc(4'd1, 4'd2, 4'd0, 8'd3);
    mem[2] = enc(4'd2, 4'd1, 4'd2, 8'd0);
    mem[3] = enc(4'd15, 4'd0, 4'd0, 8'd0);
    model_run(10);
    release_reset();
    @(negedge clk);
    check("a_pc_after_first_edge", 32'(instr_addr), 32'd0);
    wait_halted("a", 100);
    check("a_queue_empty", 32'(exp_q.size()), 32'd0);
    check("a_nwrites", 32'(wcyc.size()), 32'd3);
    if (wcyc.size() == 3) begin
      check("a_first_latency", 32'(wcyc[0] - rel_cyc), 32'd4);
      check("a_gap1", 32'(wcyc[1] - wcyc[0]), 32'd4);
      check("a_gap2", 32'(wcyc[2] - wcyc[1]), 32'd4);
    end

    // SUB to zero, taken JZ, non-taken JZ
    do_reset("b");
    clear_mem();
    mem[0]    = enc(4'd1, 4'd1, 4'd0, 8'd7);
    mem[1]    = enc(4'd3, 4'd1, 4'd1, 8'd0);
    mem[2]    = enc(4'd9, 4'd1, 4'd0, 8'h20);
    mem[6'h20] = enc(4'd1, 4'd2, 4'd0, 8'd9);
    mem[6'h21] = enc(4'd9, 4'd2, 4'd0, 8'h30);
    mem[6'h22] = enc(4'd1, 4'd3, 4'd0, 8'd1);
    mem[6'h23] = enc(4'd15, 4'd0, 4'd0, 8'd0);
    model_run(20);
    release_reset();
    wait_halted("b", 200);
    check("b_queue_empty", 32'(exp_q.size()), 32'd0);
    check("b_nwrites", 32'(wcyc.size()), 32'd4);

    // 8-bit wrap to zero, PC wrap 63 -> 0, then reset mid-instruction
    do_reset("c");
    clear_mem();
    mem[0]  = enc(4'd1, 4'd3, 4'd0, 8'hFF);
    mem[1]  = enc(4'd1, 4'd4, 4'd0, 8'd1);
    mem[2]  = enc(4'd2, 4'd3, 4'd4, 8'd0);
    mem[3]  = enc(4'd8, 4'd0, 4'd0, 8'd62);
    mem[62] = enc(4'd1, 4'd5, 4'd0, 8'hAA);
    mem[63] = enc(4'd0, 4'd0, 4'd0, 8'd0);
    model_run(7);
    release_reset();
    repeat (30) @(negedge clk);
    check("c_queue_empty", 32'(exp_q.size()), 32'd0);
    check("c_nwrites", 32'(wcyc.size()), 32'd5);
    w0 = writes;
    do_reset("c_mid");
    check("c_mid_no_write", 32'(writes), 32'(w0));

    // halt during EXECUTE, freeze, single step, resume
    clear_mem();
    mem[0] = enc(4'd1, 4'd1, 4'd0, 8'd1);
    mem[1] = enc(4'd2, 4'd1, 4'd1, 8'd0);
    mem[2] = enc(4'd2, 4'd1, 4'd1, 8'd0);
    mem[3] = enc(4'd2, 4'd1, 4'd1, 8'd0);
    mem[4] = enc(4'd15, 4'd0, 4'd0, 8'd0);
    model_run(10);
    w0 = writes;
    release_reset();
    repeat (2) @(negedge clk);
    halt = 1'b1;
    repeat (4) @(negedge clk);
    check("d_paused", 32'(halted), 32'd1);
    check("d_paused_pc", 32'(instr_addr), 32'd1);
    check("d_first_write_done", 32'(writes - w0), 32'd1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!halted || instr_addr != 6'd1) bad++;
    end
    check("d_frozen", 32'(bad), 32'd0);
    check("d_no_write_paused", 32'(writes - w0), 32'd1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (10) @(negedge clk);
    check("d_step_one_write", 32'(writes - w0), 32'd2);
    check("d_step_repaused", 32'(halted), 32'd1);
    check("d_step_pc", 32'(instr_addr), 32'd2);
    halt = 1'b0;
    repeat (2) @(negedge clk);
    check("d_resumed", 32'(halted), 32'd0);
    wait_halted("d", 100);
    check("d_queue_empty", 32'(exp_q.size()), 32'd0);
    check("d_total_writes", 32'(writes - w0), 32'd4);

    // HLT is sticky against halt/step; reset restarts at pc 0
    do_reset("e");
    clear_mem();
    mem[0] = enc(4'd1, 4'd2, 4'd0, 8'h11);
    mem[1] = enc(4'd15, 4'd0, 4'd0, 8'd0);
    model_run(10);
    release_reset();
    wait_halted("e", 50);
    repeat (2) @(negedge clk);
    check("e_queue_empty", 32'(exp_q.size()), 32'd0);
    w0 = writes;
    bad = 0;
    repeat (40) begin
      halt = 1'($urandom_range(0, 1));
      step = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!halted) bad++;
    end
    check("e_sticky_halted", 32'(bad), 32'd0);
    check("e_no_writes", 32'(writes), 32'(w0));
    do_reset("e2");
    model_run(10);
    release_reset();
    @(negedge clk);
    check("e2_restart_pc", 32'(instr_addr), 32'd0);
    check("e2_running", 32'(halted), 32'd0);
    wait_halted("e2", 50);
    check("e2_queue_empty", 32'(exp_q.size()), 32'd0);

    // random ALU program
    do_reset("f");
    clear_mem();
    for (int i = 0; i < 4; i++)
      mem[i] = enc(4'd1, 4'(i), 4'd0, 8'($urandom_range(0, 255)));
    for (int i = 4; i < 16; i++)
      mem[i] = enc(4'($urandom_range(2, 7)), 4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    mem[16] = enc(4'd15, 4'd0, 4'd0, 8'd0);
    model_run(30);
    release_reset();
    wait_halted("f", 150);
    check("f_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
